output_display_module: RTL and testbench

Downstream consumer of the output register in the ASAP-1 datapath. Takes the 8-bit value held by the output register, converts it to three BCD digits with a sequential shift-and-add-3 (double-dabble) engine, and drives a time-multiplexed three-digit seven-segment display with leading-zero blanking. It is instantiated next to the output register and connected to its `data` output; it never drives the bus.

---
 rtl/output_display_module.sv | 131 +++++++++++++
 tb/tb_output_display_module.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_display_module.sv
// Output display: converts the output register value to three BCD digits
// with a sequential double-dabble engine and scans them onto a multiplexed
// three-digit seven-segment display with leading-zero blanking.
module output_display_module #(
    parameter int REFRESH_BITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic [11:0] bcd,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state_q;
    logic [7:0]              lastValue_q;
    logic [19:0]             shiftReg_q;
    logic [19:0]             shiftReg_d;
    logic [19:0]             adjusted;
    logic [2:0]              count_q;
    logic                    busy_q;
    logic [11:0]             bcd_q;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]              digit_q;
    logic [3:0]              selNibble;
    logic                    blank;

    // One double-dabble step: add 3 to every BCD nibble that is 5 or more, then shift left.
    always_comb begin
        adjusted = shiftReg_q;
        if (shiftReg_q[19:16] >= 4'd5) adjusted[19:16] = shiftReg_q[19:16] + 4'd3;
        if (shiftReg_q[15:12] >= 4'd5) adjusted[15:12] = shiftReg_q[15:12] + 4'd3;
        if (shiftReg_q[11:8]  >= 4'd5) adjusted[11:8]  = shiftReg_q[11:8]  + 4'd3;
        shiftReg_d = {adjusted[18:0], 1'b0};
    end

    // Conversion FSM: capture a changed input, run eight steps, publish the BCD result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lastValue_q <= 8'h00;
            shiftReg_q  <= 20'h00000;
            count_q     <= 3'd0;
            busy_q      <= 1'b0;
            bcd_q       <= 12'h000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data != lastValue_q) begin
                        shiftReg_q  <= {12'h000, data};
                        lastValue_q <= data;
                        count_q     <= 3'd0;
                        busy_q      <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shiftReg_q <= shiftReg_d;
                    count_q    <= count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        bcd_q   <= shiftReg_d[19:8];
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Free-running refresh counter; each wrap moves the scan to the next digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_q <= '0;
            digit_q   <= 2'd0;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            if (&refresh_q) begin
                digit_q <= (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
            end
        end
    end

    // Digit select, nibble mux, leading-zero blanking and segment decode.
    always_comb begin
        an        = 3'b001;
        selNibble = bcd_q[3:0];
        blank     = 1'b0;
        case (digit_q)
            2'd1: begin
                an        = 3'b010;
                selNibble = bcd_q[7:4];
                blank     = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            2'd2: begin
                an        = 3'b100;
                selNibble = bcd_q[11:8];
                blank     = (bcd_q[11:8] == 4'd0);
            end
            default: begin
                an        = 3'b001;
                selNibble = bcd_q[3:0];
                blank     = 1'b0;
            end
        endcase
        case (selNibble)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        if (blank) seg = 7'h00;
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_output_display_module.sv
// Bench for output_display_module: a value-level reference model is checked
// against the DUT on every falling edge, plus directed literal checks.
module tb_output_display_module;

    localparam int RB = 2;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic [6:0] seg;
    logic [2:0] an;
    logic [11:0] bcd;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model state, expressed as values rather than shift steps
    int mLast    = 0;
    int mBusy    = 0;
    int mRemain  = 0;
    int mPending = 0;
    int mValue   = 0;
    int mEdges   = 0;

    logic [6:0] segTable [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    output_display_module #(.REFRESH_BITS(RB)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .seg  (seg),
        .an   (an),
        .bcd  (bcd),
        .busy (busy)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [11:0] toBcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    // Model update on each rising edge or asynchronous reset
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mLast = 0; mBusy = 0; mRemain = 0; mPending = 0; mValue = 0; mEdges = 0;
            end else begin
                mEdges++;
                if (mBusy != 0) begin
                    mRemain--;
                    if (mRemain == 0) begin
                        mValue = mPending;
                        mBusy  = 0;
                    end
                end else if (int'(data) != mLast) begin
                    mLast    = int'(data);
                    mPending = int'(data);
                    mBusy    = 1;
                    mRemain  = 8;
                end
            end
        end
    end

    // Compare process: DUT against model on every falling edge
    initial begin
        int idx, digitVal;
        logic [6:0] expSeg;
        forever begin
            @(negedge clk);
            idx = (mEdges >> RB) % 3;
            case (idx)
                0: digitVal = mValue % 10;
                1: digitVal = (mValue / 10) % 10;
                default: digitVal = mValue / 100;
            endcase
            expSeg = segTable[digitVal];
            if (idx == 2 && mValue < 100) expSeg = 7'h00;
            if (idx == 1 && mValue < 10)  expSeg = 7'h00;
            checkOutput("model_bcd", int'(bcd), int'(toBcd(mValue)));
            checkOutput("model_busy", int'(busy), mBusy);
            checkOutput("model_an", int'(an), 1 << idx);
            checkOutput("model_seg", int'(seg), int'(expSeg));
        end
    end

    task automatic applyStimulus(input logic [7:0] value);
        @(negedge clk);
        data = value;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scan one full frame and check literal segment values per digit slot
    task automatic checkDigits(input logic [6:0] units, input logic [6:0] tens, input logic [6:0] hundreds);
        logic [2:0] seen;
        seen = 3'b000;
        for (int i = 0; i < 3 * (1 << RB); i++) begin
            @(negedge clk);
            seen = seen | an;
            case (an)
                3'b001:  checkOutput("seg_units", int'(seg), int'(units));
                3'b010:  checkOutput("seg_tens", int'(seg), int'(tens));
                3'b100:  checkOutput("seg_hundreds", int'(seg), int'(hundreds));
                default: checkOutput("an_onehot", int'(an), 1);
            endcase
        end
        checkOutput("an_all_slots", int'(seen), 7);
    endtask

    // Directed and randomized stimulus
    initial begin
        int busyCount;
        rst  = 1'b0;
        data = 8'd0;
        #23;
        $display("[TB] reset state");
        checkOutput("reset_bcd", int'(bcd), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_an", int'(an), 1);
        checkOutput("reset_seg", int'(seg), 8'h3F);
        @(negedge clk);
        rst = 1'b1;
        busyCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busyCount++;
        end
        checkOutput("zero_no_conv", busyCount, 0);

        $display("[TB] value 255");
        applyStimulus(8'd255);
        busyCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) busyCount++;
        end
        checkOutput("busy_len_255", busyCount, 8);
        checkOutput("bcd_255", int'(bcd), 12'h255);
        checkDigits(7'h6D, 7'h6D, 7'h5B);

        $display("[TB] value 7 and 100");
        applyStimulus(8'd7);
        waitCycles(12);
        checkOutput("bcd_7", int'(bcd), 12'h007);
        checkDigits(7'h07, 7'h00, 7'h00);
        applyStimulus(8'd100);
        waitCycles(12);
        checkOutput("bcd_100", int'(bcd), 12'h100);
        checkDigits(7'h3F, 7'h3F, 7'h06);

        $display("[TB] back-to-back 42 then 199");
        applyStimulus(8'd42);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        data = 8'd199;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("bcd_42_E8", int'(bcd), 12'h042);
        checkOutput("busy_E8", int'(busy), 0);
        @(posedge clk);
        #1;
        checkOutput("busy_E9", int'(busy), 1);
        checkOutput("bcd_hold_E9", int'(bcd), 12'h042);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("bcd_199_E17", int'(bcd), 12'h199);
        checkOutput("busy_E17", int'(busy), 0);

        $display("[TB] reset mid-conversion");
        applyStimulus(8'd128);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_bcd", int'(bcd), 0);
        checkOutput("abort_an", int'(an), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("rerun_busy_E7", int'(busy), 1);
        @(posedge clk);
        #1;
        checkOutput("bcd_128", int'(bcd), 12'h128);
        checkOutput("rerun_busy_E8", int'(busy), 0);

        $display("[TB] sweep 0..255");
        for (int v = 0; v < 256; v++) begin
            applyStimulus(8'(v));
            waitCycles(10);
            checkOutput("sweep_bcd", int'(bcd), int'(toBcd(v)));
        end

        $display("[TB] random stimulus");
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) data = 8'($urandom_range(0, 255));
        end
        waitCycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
